// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational instruction memory,
// and presents each fetched word to decode through a registered valid/ready stage.
module ifu_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          IM_WORDS = 1024
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] im_addr,
   input  logic [31:0] im_rd,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fetch_err,
   output logic [1:0]  state_o
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2,
      FAULT  = 2'd3
   } state_t;

   localparam logic [31:0] PC_MAX = RESET_PC + 32'(4 * (IM_WORDS - 1));

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic        out_valid_n;
   logic [31:0] out_instr_n, out_pc_n;
   logic        fetch_err_n;
   logic        slot_free;

   function automatic logic legal(input logic [31:0] x);
      return (x[1:0] == 2'b00) && (x >= RESET_PC) && (x <= PC_MAX);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= BOOT;
         pc        <= RESET_PC;
         out_valid <= 1'b0;
         out_instr <= 32'h0;
         out_pc    <= 32'h0;
         fetch_err <= 1'b0;
      end else begin
         state     <= state_n;
         pc        <= pc_n;
         out_valid <= out_valid_n;
         out_instr <= out_instr_n;
         out_pc    <= out_pc_n;
         fetch_err <= fetch_err_n;
      end
   end

   assign slot_free = !out_valid || out_ready;

   // A redirect always flushes the stage, even when decode consumes the word this cycle.
   always_comb begin
      state_n     = state;
      pc_n        = pc;
      out_valid_n = out_valid;
      out_instr_n = out_instr;
      out_pc_n    = out_pc;
      fetch_err_n = fetch_err;
      unique case (state)
         BOOT: begin
            out_valid_n = 1'b0;
            state_n     = RUN;
         end
         RUN: begin
            if (redirect_valid) begin
               out_valid_n = 1'b0;
               if (legal(redirect_pc)) begin
                  pc_n = redirect_pc;
               end else begin
                  fetch_err_n = 1'b1;
                  state_n     = FAULT;
               end
            end else if (halt && slot_free) begin
               out_valid_n = 1'b0;
               state_n     = HALTED;
            end else if (slot_free && legal(pc)) begin
               out_instr_n = im_rd;
               out_pc_n    = pc;
               out_valid_n = 1'b1;
               pc_n        = pc + 32'd4;
            end else if (slot_free) begin
               out_valid_n = 1'b0;
               fetch_err_n = 1'b1;
               state_n     = FAULT;
            end
         end
         HALTED: begin
            out_valid_n = 1'b0;
            if (redirect_valid) begin
               if (legal(redirect_pc)) begin
                  pc_n    = redirect_pc;
                  state_n = RUN;
               end else begin
                  fetch_err_n = 1'b1;
                  state_n     = FAULT;
               end
            end else if (!halt) begin
               state_n = RUN;
            end
         end
         FAULT: begin
            out_valid_n = 1'b0;
            if (redirect_valid && legal(redirect_pc)) begin
               fetch_err_n = 1'b0;
               pc_n        = redirect_pc;
               state_n     = RUN;
            end
         end
         default: state_n = BOOT;
      endcase
   end

   always_comb begin
      im_addr = pc;
      state_o = state;
   end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: sequential fetch, backpressure, redirects,
// illegal targets, end of memory, halt and asynchronous reset.
module tb_ifu_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] im_addr;
   logic [31:0] im_rd;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        fetch_err;
   logic [1:0]  state_o;

   logic [31:0] mem [0:1023];
   int          n_checks = 0;
   int          n_errors = 0;

   ifu_fetch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .im_addr        (im_addr),
      .im_rd          (im_rd),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .fetch_err      (fetch_err),
      .state_o        (state_o)
   );

   always #5 clk = ~clk;

   assign im_rd = mem[im_addr[11:2]];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic h, input logic rdy);
      redirect_valid = rv;
      redirect_pc    = rpc;
      halt           = h;
      out_ready      = rdy;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkStage(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] instr);
      checkOutput({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
      if (v) begin
         checkOutput({tag, ".pc"}, out_pc, pc);
         checkOutput({tag, ".instr"}, out_instr, instr);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | 32'(i);
      mem[0] = 32'h1111_1111;
      mem[1] = 32'h2222_2222;
      mem[2] = 32'h3333_3333;

      reset = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      repeat (3) step();

      // reset state
      checkOutput("rst.valid", {31'b0, out_valid}, 32'h0);
      checkOutput("rst.pc", out_pc, 32'h0);
      checkOutput("rst.instr", out_instr, 32'h0);
      checkOutput("rst.err", {31'b0, fetch_err}, 32'h0);
      checkOutput("rst.state", {30'b0, state_o}, 32'd0);
      checkOutput("rst.im_addr", im_addr, 32'h3000);

      // sequential fetch
      reset = 1'b1;
      step();
      checkOutput("boot.state", {30'b0, state_o}, 32'd1);
      checkStage("boot", 1'b0, 32'h0, 32'h0);
      step();
      checkStage("seq0", 1'b1, 32'h3000, 32'h1111_1111);
      step();
      checkStage("seq1", 1'b1, 32'h3004, 32'h2222_2222);
      checkOutput("seq1.im_addr", im_addr, 32'h3008);

      // backpressure
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         checkStage("hold", 1'b1, 32'h3004, 32'h2222_2222);
         checkOutput("hold.im_addr", im_addr, 32'h3008);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkStage("seq2", 1'b1, 32'h3008, 32'h3333_3333);

      // redirect flush
      applyStimulus(1'b1, 32'h3100, 1'b0, 1'b1);
      step();
      checkStage("redir.flush", 1'b0, 32'h0, 32'h0);
      checkOutput("redir.im_addr", im_addr, 32'h3100);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkStage("redir.tgt", 1'b1, 32'h3100, 32'hA000_0040);
      step();
      checkStage("redir.next", 1'b1, 32'h3104, 32'hA000_0041);

      // illegal redirect, then recovery
      applyStimulus(1'b1, 32'h3102, 1'b0, 1'b1);
      step();
      checkOutput("ill.err", {31'b0, fetch_err}, 32'h1);
      checkOutput("ill.state", {30'b0, state_o}, 32'd3);
      checkStage("ill", 1'b0, 32'h0, 32'h0);
      checkOutput("ill.im_addr", im_addr, 32'h3108);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkOutput("fault.stay", {30'b0, state_o}, 32'd3);
      checkStage("fault", 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 32'h3000, 1'b0, 1'b1);
      step();
      checkOutput("rec.err", {31'b0, fetch_err}, 32'h0);
      checkOutput("rec.state", {30'b0, state_o}, 32'd1);
      checkOutput("rec.im_addr", im_addr, 32'h3000);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkStage("rec.tgt", 1'b1, 32'h3000, 32'h1111_1111);

      // end of memory
      applyStimulus(1'b1, 32'h3FFC, 1'b0, 1'b1);
      step();
      checkStage("eom.flush", 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkStage("eom.last", 1'b1, 32'h3FFC, 32'hA000_03FF);
      step();
      checkStage("eom.past", 1'b0, 32'h0, 32'h0);
      checkOutput("eom.err", {31'b0, fetch_err}, 32'h1);
      checkOutput("eom.state", {30'b0, state_o}, 32'd3);
      step();
      checkStage("eom.stay", 1'b0, 32'h0, 32'h0);

      // halt
      applyStimulus(1'b1, 32'h3000, 1'b0, 1'b1);
      step();
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkStage("pre.halt", 1'b1, 32'h3000, 32'h1111_1111);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      step();
      checkOutput("halt.state", {30'b0, state_o}, 32'd2);
      checkStage("halt", 1'b0, 32'h0, 32'h0);
      step();
      checkOutput("halt.im_addr", im_addr, 32'h3004);
      checkOutput("halt.stay", {30'b0, state_o}, 32'd2);
      applyStimulus(1'b1, 32'h3040, 1'b1, 1'b1);
      step();
      checkOutput("unhalt.state", {30'b0, state_o}, 32'd1);
      checkStage("unhalt", 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      step();
      checkStage("unhalt.tgt", 1'b1, 32'h3040, 32'hA000_0010);
      step();
      checkStage("run.next", 1'b1, 32'h3044, 32'hA000_0011);

      // asynchronous reset mid-stream
      #2 reset = 1'b0;
      #1;
      checkStage("arst", 1'b0, 32'h0, 32'h0);
      checkOutput("arst.pc", out_pc, 32'h0);
      checkOutput("arst.instr", out_instr, 32'h0);
      checkOutput("arst.state", {30'b0, state_o}, 32'd0);
      checkOutput("arst.im_addr", im_addr, 32'h3000);
      step();
      reset = 1'b1;
      step();
      checkOutput("arst.boot", {30'b0, state_o}, 32'd1);
      step();
      checkStage("arst.restart", 1'b1, 32'h3000, 32'h1111_1111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the MIPS core.
- Owns the PC and drives the word address into the combinational instruction memory: 1024 words, indexed by A[11:2], base 0x0000_3000.
- Registers each fetched word into a valid/ready output stage for decode.
- Handles branch/jump redirects, halt, and out-of-range or misaligned PCs.

Parameters:
- RESET_PC, 32'h0000_3000: PC loaded on reset; base of instruction memory.
- IM_WORDS, 1024: memory depth in words. Legal PC range is RESET_PC to RESET_PC+4*IM_WORDS-4.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- im_addr  output  32  byte address to instruction memory; equals pc, combinational.
- im_rd  input  32  instruction word returned combinationally for im_addr.
- redirect_valid  input  1  load redirect_pc (taken branch/jump/jr).
- redirect_pc  input  32  target PC.
- halt  input  1  stop fetching after the current output is consumed.
- out_valid  output  1  out_instr/out_pc valid to decode.
- out_ready  input  1  decode accepts the current output this cycle.
- out_instr  output  32  registered instruction word.
- out_pc  output  32  PC of out_instr.
- fetch_err  output  1  sticky fault flag; set by an illegal PC, cleared by a legal redirect.
- state_o  output  2  current state, for debug.

Behaviour:
- Reset values (asynchronous on reset=0): pc=RESET_PC, state=BOOT, out_valid=0, out_instr=0, out_pc=0, fetch_err=0.
- Definitions:
  - legal(x) = x[1:0]==0 && x>=RESET_PC && x<=RESET_PC+4*(IM_WORDS-1). Unsigned compare.
  - slot_free = !out_valid || out_ready.
- States: BOOT=0, RUN=1, HALTED=2, FAULT=3.
- BOOT: one cycle with out_valid=0, no fetch. Next state is RUN. Gives instruction memory contents one cycle after reset release.
- RUN, evaluated in this priority order:
  1. redirect_valid:
     - out_valid<=0 (flush the in-flight word even if out_ready=1 this cycle).
     - If legal(redirect_pc): pc<=redirect_pc, stay in RUN.
     - Else: fetch_err<=1, state<=FAULT, pc unchanged.
  2. halt && slot_free: out_valid<=0, state<=HALTED.
  3. slot_free && legal(pc): out_instr<=im_rd, out_pc<=pc, out_valid<=1, pc<=pc+4.
  4. slot_free && !legal(pc): out_valid<=0, fetch_err<=1, state<=FAULT.
  5. Otherwise (out_valid && !out_ready): hold all outputs and pc.
- Latency and throughput:
  - Redirect asserted in cycle N: the target word is presented with out_valid=1 at the edge ending cycle N+1.
  - Steady state: one instruction per cycle while out_ready=1.
- HALTED: out_valid=0, pc frozen.
  - redirect_valid with legal target: pc<=redirect_pc, state<=RUN.
  - redirect_valid with illegal target: fetch_err<=1, state<=FAULT.
  - halt deasserted without redirect: state<=RUN, resume at frozen pc.
- FAULT: out_valid=0, no fetch, fetch_err=1.
  - Only redirect_valid with a legal target exits: fetch_err<=0, pc<=target, state<=RUN.
- Boundary conditions:
  - End of memory: pc=RESET_PC+4*IM_WORDS-4 fetches normally. The next pc is one past the end, so the following cycle enters FAULT. No wrap to RESET_PC.
  - Simultaneous redirect and halt: the redirect is taken; halt is re-evaluated next cycle.
  - Simultaneous redirect and out_ready: the handshake for the current word completes (decode consumes it); the next word is from the target.
  - Reset mid-operation: immediate asynchronous return to reset values. Any held word is discarded.
  - pc+4 is a 32-bit wrap-free add; overflow is impossible within the legal range.

Test Plan:
- Sequential fetch: reset, IM holds 0x11111111 at 0x3000, 0x22222222 at 0x3004, 0x33333333 at 0x3008. out_ready=1 throughout -> out_valid first rises 2 cycles after reset release; out_pc/out_instr = 0x3000/0x11111111, 0x3004/0x22222222, 0x3008/0x33333333 on consecutive cycles.
- Backpressure: out_ready=0 for 3 cycles while out_pc=0x3004 -> out_pc, out_instr and im_addr=0x3008 held. Then out_ready=1 -> next output is 0x3008 and nothing is skipped.
- Redirect flush: redirect_valid=1, redirect_pc=0x3100 while out_pc=0x3004 valid -> next cycle out_valid=0; the following cycle out_pc=0x3100 with the IM word at 0x3100.
- Illegal redirect: redirect_pc=0x3102 -> fetch_err=1, state_o=3, out_valid=0. Then redirect_pc=0x3000 -> fetch_err=0, fetch resumes at 0x3000.
- End of memory: redirect_pc=0x3FFC -> 0x3FFC is delivered, then fetch_err=1, state_o=3. No output with out_pc=0x4000 or 0x3000 appears.
- Halt and async reset: halt=1 with out_ready=1 -> state_o=2, out_valid=0. Redirect to 0x3040 -> RUN, out_pc=0x3040 next. Pulse reset low mid-stream -> outputs zero immediately, restart at 0x3000.
